// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter: port-owner encoding,
// default display geometry and the "no display request" coordinate.
package vga_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_WR   = 2'd2,
        OWN_RD   = 2'd3
    } owner_e;

    localparam int         H_ACT_DEF = 640;
    localparam int         V_ACT_DEF = 480;
    localparam logic [9:0] PIX_NONE  = 10'h3FF;

endpackage

// File: rtl/vga_fb_arb_if.sv
// Processing-engine side of the frame-buffer arbiter: posted-write and
// read handshakes plus the read return.
interface vga_fb_arb_if #(
    parameter int AW = 19
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid;
    logic [7:0]    rd_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_rvalid, rd_rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_rvalid, rd_rdata
    );
endinterface

// File: rtl/wr_fifo.sv
// Posted-write FIFO: synchronous, DEPTH entries (power of 2), W bits wide.
// The head is visible on dout without a read latency; a pushed entry shows
// up at the head no earlier than the following cycle.
module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 27
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];

    // Pointer and occupancy bookkeeping; reset drops every queued entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/vga_fb_arb.sv
// Single-port frame-buffer arbiter. Each cycle exactly one owner drives the
// RAM port; the registered owner (r_owner_q) routes the RAM data returned
// one cycle later to the display or to the read-return port.
//
//   owner     | meaning
//   OWN_IDLE  | no access, RAM address/data held, no write
//   OWN_DISP  | display pixel fetch, never stalled
//   OWN_WR    | drain FIFO head to RAM
//   OWN_RD    | engine read, only when no posted write is outstanding
module vga_fb_arb
    import vga_pkg::*;
#(
    parameter int H_ACT    = H_ACT_DEF,
    parameter int V_ACT    = V_ACT_DEF,
    parameter int AW       = 19,
    parameter int WF_DEPTH = 4
) (
    input  logic            vga_clk,
    input  logic            sys_rst_n,
    input  logic [9:0]      pix_x,
    input  logic [9:0]      pix_y,
    output logic [7:0]      pix_data,
    vga_fb_arb_if.slave     pe,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    output logic            addr_err
);
    localparam int          CW       = $clog2(WF_DEPTH) + 1;
    localparam logic [AW:0] FB_SIZE  = (AW+1)'(H_ACT * V_ACT);
    localparam logic [31:0] H_STRIDE = 32'(H_ACT);

    owner_e          w_owner;
    owner_e          r_owner_q;
    logic            w_disp_req;
    logic [AW-1:0]   w_disp_addr;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_fifo_cnt;
    logic [AW+7:0]   w_head;
    logic [AW-1:0]   w_head_addr;
    logic [7:0]      w_head_data;
    logic            w_wr_oor;
    logic            w_rd_oor;
    logic            w_rvalid;
    logic [7:0]      w_rdata;
    logic [AW-1:0]   r_addr_hold;
    logic [7:0]      r_wdata_hold;
    logic [7:0]      r_rdata_hold;
    logic            r_rd_oor_q;
    logic            r_addr_err;

    // Row base = y * H_ACT built from the set bits of the stride (640 -> y<<9 + y<<7).
    function automatic logic [AW-1:0] row_base(input logic [9:0] y);
        logic [AW-1:0] acc;
        acc = '0;
        for (int b = 0; b < 32; b++) begin
            if (H_STRIDE[b]) acc = acc + (AW'(y) << b);
        end
        return acc;
    endfunction

    wr_fifo #(
        .DEPTH (WF_DEPTH),
        .W     (AW + 8)
    ) u_fifo (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .push  (w_push),
        .din   ({pe.wr_addr, pe.wr_data}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_cnt)
    );

    assign w_disp_req               = (pix_x != PIX_NONE) && (pix_y != PIX_NONE);
    assign w_disp_addr              = row_base(pix_y) + AW'(pix_x);
    assign {w_head_addr, w_head_data} = w_head;
    assign w_wr_oor                 = ({1'b0, w_head_addr} >= FB_SIZE);
    assign w_rd_oor                 = ({1'b0, pe.rd_addr} >= FB_SIZE);

    // Fixed-priority owner select; reset parks the port in IDLE.
    always_comb begin
        w_owner = OWN_IDLE;
        if (!sys_rst_n)                            w_owner = OWN_IDLE;
        else if (w_disp_req)                       w_owner = OWN_DISP;
        else if (!w_empty)                         w_owner = OWN_WR;
        else if (pe.rd_valid && w_fifo_cnt == '0)  w_owner = OWN_RD;
    end

    assign w_push      = pe.wr_valid && pe.wr_ready;
    assign w_pop       = (w_owner == OWN_WR);
    assign pe.wr_ready = sys_rst_n && !w_full;
    assign pe.rd_ready = (w_owner == OWN_RD);

    // RAM port mux; out-of-range writes still pop but never reach the RAM.
    always_comb begin
        mem_addr  = r_addr_hold;
        mem_wdata = r_wdata_hold;
        mem_we    = 1'b0;
        case (w_owner)
            OWN_DISP: mem_addr = w_disp_addr;
            OWN_WR: begin
                mem_addr  = w_head_addr;
                mem_wdata = w_head_data;
                mem_we    = !w_wr_oor;
            end
            OWN_RD:   mem_addr = pe.rd_addr;
            default:  ;
        endcase
    end

    // Owner history, read-return bookkeeping, sticky range error and IDLE hold values.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            r_owner_q    <= OWN_IDLE;
            r_rd_oor_q   <= 1'b0;
            r_rdata_hold <= 8'h00;
            r_addr_err   <= 1'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= 8'h00;
        end else begin
            r_owner_q    <= w_owner;
            r_rd_oor_q   <= (w_owner == OWN_RD) && w_rd_oor;
            r_addr_hold  <= mem_addr;
            r_wdata_hold <= mem_wdata;
            if (w_rvalid) r_rdata_hold <= w_rdata;
            if (((w_owner == OWN_WR) && w_wr_oor) || ((w_owner == OWN_RD) && w_rd_oor))
                r_addr_err <= 1'b1;
        end
    end

    // A reset landing on the return cycle swallows the pending read data.
    assign w_rvalid     = sys_rst_n && (r_owner_q == OWN_RD);
    assign w_rdata      = w_rvalid ? (r_rd_oor_q ? 8'h00 : mem_rdata) : r_rdata_hold;
    assign pe.rd_rvalid = w_rvalid;
    assign pe.rd_rdata  = w_rdata;
    assign pix_data     = (r_owner_q == OWN_DISP) ? mem_rdata : 8'h00;
    assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_vga_fb_arb.sv
// Self-checking bench for vga_fb_arb with a behavioural RAM (preload = addr[7:0])
// and a scoreboard for display pixels, RAM writes and read returns.
module tb_vga_fb_arb;
    import vga_pkg::*;

    localparam int AW = 19;
    localparam int HA = 640;
    localparam int VA = 480;

    logic          vga_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic [7:0]    pix_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          addr_err;

    vga_fb_arb_if #(.AW(AW)) pe ();

    vga_fb_arb #(
        .H_ACT    (HA),
        .V_ACT    (VA),
        .AW       (AW),
        .WF_DEPTH (4)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data),
        .pe        (pe),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .addr_err  (addr_err)
    );

    always #5 vga_clk = ~vga_clk;

    // Frame-buffer RAM: registered read, unwritten locations read as addr[7:0].
    logic [7:0] ram    [0:(1<<AW)-1];
    bit         ram_wr [0:(1<<AW)-1];
    always @(posedge vga_clk) begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame-buffer contents as the bench believes them.
    logic [7:0] shadow [int];
    function automatic logic [7:0] model_rd(input int a);
        if (a >= HA * VA) return 8'h00;
        if (shadow.exists(a)) return shadow[a];
        return a[7:0];
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic [7:0] pixq [$];
    wr_t        wq   [$];
    logic [7:0] rq   [$];

    // Scoreboard: compare last cycle's expectations, then record this cycle's stimulus.
    always @(negedge vga_clk) begin
        logic [7:0] e;
        wr_t        w;
        int         a;
        if (pixq.size() > 0) begin
            e = pixq.pop_front();
            check_val("pix_data", 32'(pix_data), 32'(e));
        end
        if (sys_rst_n && pix_x != PIX_NONE && pix_y != PIX_NONE) begin
            a = int'(pix_y) * HA + int'(pix_x);
            pixq.push_back(model_rd(a));
        end else begin
            pixq.push_back(8'h00);
        end
        if (mem_we) begin
            if (wq.size() == 0) begin
                check_val("mem_we_unexp", 32'(mem_we), 32'(0));
            end else begin
                w = wq.pop_front();
                check_val("wr_addr", 32'(mem_addr), 32'(w.a));
                check_val("wr_data", 32'(mem_wdata), 32'(w.d));
                shadow[int'(w.a)] = w.d;
            end
        end
        if (pe.rd_rvalid) begin
            if (rq.size() == 0) begin
                check_val("rvalid_unexp", 32'(pe.rd_rvalid), 32'(0));
            end else begin
                e = rq.pop_front();
                check_val("rd_rdata", 32'(pe.rd_rdata), 32'(e));
            end
        end
        if (!sys_rst_n) begin
            wq.delete();
            rq.delete();
        end else begin
            if (pe.wr_valid && pe.wr_ready && int'(pe.wr_addr) < HA * VA)
                wq.push_back('{a: pe.wr_addr, d: pe.wr_data});
            if (pe.rd_valid && pe.rd_ready)
                rq.push_back(model_rd(int'(pe.rd_addr)));
        end
    end

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
    endtask

    task automatic wr_beat(input int a, input int d);
        int t;
        t = 0;
        pe.wr_valid = 1'b1;
        pe.wr_addr  = AW'(a);
        pe.wr_data  = 8'(d);
        @(negedge vga_clk);
        while (!pe.wr_ready && t < 50) begin
            @(negedge vga_clk);
            t++;
        end
        check_val("wr_accept", 32'(pe.wr_ready), 32'(1));
        cyc();
        pe.wr_valid = 1'b0;
    endtask

    task automatic rd_req(input int a);
        int t;
        t = 0;
        pe.rd_valid = 1'b1;
        pe.rd_addr  = AW'(a);
        @(negedge vga_clk);
        while (!pe.rd_ready && t < 50) begin
            @(negedge vga_clk);
            t++;
        end
        check_val("rd_grant", 32'(pe.rd_ready), 32'(1));
        cyc();
        pe.rd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_x       = PIX_NONE;
        pix_y       = PIX_NONE;
        pe.wr_valid = 1'b0;
        pe.wr_addr  = '0;
        pe.wr_data  = 8'h00;
        pe.rd_valid = 1'b0;
        pe.rd_addr  = '0;

        // Reset holds every handshake and the RAM write enable low.
        repeat (3) cyc();
        pe.wr_valid = 1'b1;
        pe.rd_valid = 1'b1;
        set_pix(5, 0);
        @(negedge vga_clk);
        check_val("rst_wr_ready", 32'(pe.wr_ready), 32'(0));
        check_val("rst_rd_ready", 32'(pe.rd_ready), 32'(0));
        check_val("rst_mem_we", 32'(mem_we), 32'(0));
        check_val("rst_rvalid", 32'(pe.rd_rvalid), 32'(0));
        check_val("rst_addr_err", 32'(addr_err), 32'(0));
        check_val("rst_rdata", 32'(pe.rd_rdata), 32'(0));
        cyc();
        pe.wr_valid = 1'b0;
        pe.rd_valid = 1'b0;
        set_pix(1023, 1023);
        sys_rst_n = 1'b1;
        cyc();
        check_val("rst_cnt", 32'(dut.w_fifo_cnt), 32'(0));

        // Continuous display line 0, plus stride and last-pixel samples.
        for (int x = 0; x < 640; x++) begin
            set_pix(x, 0);
            cyc();
        end
        for (int x = 0; x < 8; x++) begin
            set_pix(x, 1);
            cyc();
        end
        for (int x = 632; x < 640; x++) begin
            set_pix(x, 479);
            cyc();
        end

        // Four posted writes during active video, drained in the first blank cycles.
        set_pix(10, 2);
        for (int k = 0; k < 4; k++) wr_beat(2000 + k, 8'hA0 + k);
        @(negedge vga_clk);
        check_val("full_ready", 32'(pe.wr_ready), 32'(0));
        check_val("full_cnt", 32'(dut.w_fifo_cnt), 32'(4));
        check_val("active_no_we", 32'(mem_we), 32'(0));
        cyc();
        set_pix(1023, 1023);
        for (int k = 0; k < 4; k++) begin
            @(negedge vga_clk);
            check_val("blank_we", 32'(mem_we), 32'(1));
            cyc();
        end
        @(negedge vga_clk);
        check_val("drained_we", 32'(mem_we), 32'(0));
        check_val("drained_ready", 32'(pe.wr_ready), 32'(1));
        cyc();

        // Read after write to the same address waits for the write to drain.
        wr_beat(1000, 8'h5A);
        pe.rd_valid = 1'b1;
        pe.rd_addr  = AW'(1000);
        @(negedge vga_clk);
        check_val("rd_blocked", 32'(pe.rd_ready), 32'(0));
        check_val("rd_blocked_we", 32'(mem_we), 32'(1));
        cyc();
        rd_req(1000);
        @(negedge vga_clk);
        check_val("rvalid_pulse", 32'(pe.rd_rvalid), 32'(1));
        cyc();
        @(negedge vga_clk);
        check_val("rvalid_end", 32'(pe.rd_rvalid), 32'(0));
        check_val("rdata_hold", 32'(pe.rd_rdata), 32'(8'h5A));
        cyc();

        // Out-of-range write and read.
        wr_beat(307200, 8'h77);
        @(negedge vga_clk);
        check_val("oor_we", 32'(mem_we), 32'(0));
        cyc();
        @(negedge vga_clk);
        check_val("oor_err", 32'(addr_err), 32'(1));
        cyc();
        rd_req(307300);
        repeat (2) cyc();

        // Display pre-empts two pending writes; head and count stay put.
        set_pix(20, 3);
        wr_beat(3000, 8'hC1);
        wr_beat(3001, 8'hC2);
        @(negedge vga_clk);
        check_val("pre_cnt", 32'(dut.w_fifo_cnt), 32'(2));
        check_val("pre_we", 32'(mem_we), 32'(0));
        check_val("pre_addr", 32'(mem_addr), 32'(3 * 640 + 20));
        check_val("pre_head_a", 32'(dut.w_head_addr), 32'(3000));
        cyc();
        @(negedge vga_clk);
        check_val("pre_cnt2", 32'(dut.w_fifo_cnt), 32'(2));
        check_val("pre_head_a2", 32'(dut.w_head_addr), 32'(3000));
        check_val("pre_head_d2", 32'(dut.w_head_data), 32'(8'hC1));
        check_val("err_sticky", 32'(addr_err), 32'(1));
        cyc();
        set_pix(1023, 1023);
        repeat (3) cyc();

        // Reset on the return cycle of a granted read.
        pe.rd_valid = 1'b1;
        pe.rd_addr  = AW'(500);
        @(negedge vga_clk);
        check_val("rif_grant", 32'(pe.rd_ready), 32'(1));
        cyc();
        pe.rd_valid = 1'b0;
        sys_rst_n   = 1'b0;
        @(negedge vga_clk);
        check_val("rif_rvalid0", 32'(pe.rd_rvalid), 32'(0));
        cyc();
        sys_rst_n = 1'b1;
        @(negedge vga_clk);
        check_val("rif_rvalid1", 32'(pe.rd_rvalid), 32'(0));
        check_val("rif_err_clr", 32'(addr_err), 32'(0));
        cyc();

        // Reset with three writes queued discards them.
        set_pix(1, 1);
        for (int k = 0; k < 3; k++) wr_beat(4000 + k, 8'hE0 + k);
        @(negedge vga_clk);
        check_val("q3_cnt", 32'(dut.w_fifo_cnt), 32'(3));
        cyc();
        set_pix(1023, 1023);
        sys_rst_n = 1'b0;
        @(negedge vga_clk);
        check_val("q3_rst_we", 32'(mem_we), 32'(0));
        check_val("q3_rst_ready", 32'(pe.wr_ready), 32'(0));
        cyc();
        sys_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge vga_clk);
            check_val("q3_post_we", 32'(mem_we), 32'(0));
            check_val("q3_post_cnt", 32'(dut.w_fifo_cnt), 32'(0));
            check_val("q3_post_rv", 32'(pe.rd_rvalid), 32'(0));
            cyc();
        end

        repeat (3) cyc();
        check_val("sb_wq_empty", 32'(wq.size()), 32'(0));
        check_val("sb_rq_empty", 32'(rq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
